sr_piso_tx: RTL and testbench

SR_PISO_TX -- requirements
Module: sr_piso_tx

---
 rtl/sr_piso_tx.sv | 127 ++++++++++++
 tb/tb_sr_piso_tx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sr_piso_tx.sv
// sr_piso_tx: parallel-in / serial-out transmitter.
// A word accepted while ready=1 is shifted out one bit per clock. The first
// bit appears one cycle after the accepting edge. frame_start marks the first
// bit and done marks the last bit. ready is high in IDLE and again in the last
// bit cycle, so back-to-back frames run with no gap cycle.
// All outputs come directly from flops. No path runs from write or inp to an
// output without passing through a register.
// WIDTH must be at least 2.

module sr_piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [WIDTH:1] inp,
  input  logic           write,
  output logic           ready,
  output logic           sout,
  output logic           sout_valid,
  output logic           frame_start,
  output logic           done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT_CNT = CW'(WIDTH - 2);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;          // holds k-1 during bit cycle k
  logic [WIDTH:1] shreg_q;        // the bit now on sout sits at the leading end
  logic           sout_q;
  logic           sout_valid_q;
  logic           frame_start_q;
  logic           done_q;
  logic           ready_q;

  logic           accept_d;
  logic           continue_d;
  logic           first_bit_d;
  logic           next_bit_d;
  logic [WIDTH:1] shifted_d;

  // Decode the load/continue conditions and the bit-order-dependent taps.
  always_comb begin
    // NOTE: give every always_comb output a default first. A path that leaves
    // a signal unassigned would infer a latch.
    accept_d    = 1'b0;
    continue_d  = 1'b0;
    first_bit_d = 1'b0;
    next_bit_d  = 1'b0;
    shifted_d   = '0;

    accept_d   = ready_q & write;
    continue_d = (state_q == SHIFT) && (cnt_q != LAST_CNT);

    if (MSB_FIRST) begin
      first_bit_d = inp[WIDTH];
      next_bit_d  = shreg_q[WIDTH-1];
      shifted_d   = {shreg_q[WIDTH-1:1], 1'b0};
    end else begin
      first_bit_d = inp[1];
      next_bit_d  = shreg_q[2];
      shifted_d   = {1'b0, shreg_q[WIDTH:2]};
    end
  end

  // FSM, bit counter, shift register and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled only at the clock edge, so it sits inside the
    // clocked block rather than in the sensitivity list. Reset takes priority
    // over a write arriving at the same edge.
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples the values that were present before the edge.
      state_q       <= IDLE;
      cnt_q         <= '0;
      shreg_q       <= '0;
      sout_q        <= 1'b0;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
      ready_q       <= 1'b1;
    end else if (accept_d) begin
      // Load a new word. This also covers a write in the last bit cycle.
      state_q       <= SHIFT;
      cnt_q         <= '0;
      shreg_q       <= inp;
      sout_q        <= first_bit_d;
      sout_valid_q  <= 1'b1;
      frame_start_q <= 1'b1;
      done_q        <= 1'b0;
      ready_q       <= 1'b0;
    end else if (continue_d) begin
      // Move on to the next bit. The flags look one cycle ahead so that they
      // line up with the bit they describe.
      cnt_q         <= cnt_q + 1'b1;
      shreg_q       <= shifted_d;
      sout_q        <= next_bit_d;
      sout_valid_q  <= 1'b1;
      frame_start_q <= 1'b0;
      done_q        <= (cnt_q == PENULT_CNT);
      ready_q       <= (cnt_q == PENULT_CNT);
    end else begin
      // Idle, or the last bit has ended with no new write.
      state_q       <= IDLE;
      cnt_q         <= '0;
      sout_q        <= 1'b0;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
      ready_q       <= 1'b1;
    end
  end

  assign ready       = ready_q;
  assign sout        = sout_q;
  assign sout_valid  = sout_valid_q;
  assign frame_start = frame_start_q;
  assign done        = done_q;

endmodule

// File: tb/tb_sr_piso_tx.sv
// tb_sr_piso_tx: scoreboard bench for sr_piso_tx (WIDTH=8). The bench drives
// one MSB-first instance and one LSB-first instance with the same stimulus.
// Each edge pops one expected output record from the queue and compares it
// with the selected instance.

module tb_sr_piso_tx;

  typedef struct packed {
    logic sout;
    logic valid;
    logic fs;
    logic done;
    logic ready;
  } obs_t;

  typedef struct {
    logic [8:1] word;
    bit         lsb;
    string      name;
  } vec_t;

  localparam obs_t IDLE_OBS = '{sout: 1'b0, valid: 1'b0, fs: 1'b0, done: 1'b0, ready: 1'b1};

  logic       clk = 1'b0;
  logic       reset;
  logic [8:1] inp;
  logic       write;

  logic m_ready, m_sout, m_valid, m_fs, m_done;
  logic l_ready, l_sout, l_valid, l_fs, l_done;

  bit   chk_lsb;
  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  sr_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .inp(inp), .write(write),
    .ready(m_ready), .sout(m_sout), .sout_valid(m_valid),
    .frame_start(m_fs), .done(m_done)
  );

  sr_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .inp(inp), .write(write),
    .ready(l_ready), .sout(l_sout), .sout_valid(l_valid),
    .frame_start(l_fs), .done(l_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t actual();
    obs_t a;
    if (chk_lsb) a = '{sout: l_sout, valid: l_valid, fs: l_fs, done: l_done, ready: l_ready};
    else         a = '{sout: m_sout, valid: m_valid, fs: m_fs, done: m_done, ready: m_ready};
    return a;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got sout=%b valid=%b start=%b done=%b ready=%b, want sout=%b valid=%b start=%b done=%b ready=%b",
               name, act.sout, act.valid, act.fs, act.done, act.ready,
               exp.sout, exp.valid, exp.fs, exp.done, exp.ready);
    end
  endtask

  // Queue the eight per-cycle observations that the spec requires for word w.
  function automatic void push_frame(input logic [8:1] w, input bit lsb);
    for (int k = 1; k <= 8; k++) begin
      obs_t o;
      o.sout  = lsb ? w[k] : w[9-k];
      o.valid = 1'b1;
      o.fs    = (k == 1);
      o.done  = (k == 8);
      o.ready = (k == 8);
      exp_q.push_back(o);
    end
  endfunction

  // Pass one clock edge, then compare the outputs with the next expected record.
  task automatic step(input string name);
    obs_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = IDLE_OBS;
    check(name, actual(), e);
  endtask

  // Present word w with write=1 for one edge, then scramble inp.
  task automatic send(input logic [8:1] w, input string name);
    write = 1'b1;
    inp   = w;
    push_frame(w, chk_lsb);
    step(name);
    write = 1'b0;
    inp   = ~w;
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{word: 8'b10100001, lsb: 1'b0, name: "msb_basic"};
    tbl[1] = '{word: 8'b10100001, lsb: 1'b1, name: "lsb_basic"};
    tbl[2] = '{word: 8'b11111111, lsb: 1'b0, name: "msb_ones"};
    tbl[3] = '{word: 8'b00000000, lsb: 1'b1, name: "lsb_zeros"};
    tbl[4] = '{word: 8'b01011010, lsb: 1'b1, name: "lsb_5a"};
    tbl[5] = '{word: 8'b11001001, lsb: 1'b0, name: "msb_c9"};

    reset   = 1'b0;
    write   = 1'b0;
    inp     = '0;
    chk_lsb = 1'b0;
    step("reset_state");
    step("reset_state");
    reset = 1'b1;
    step("idle_after_reset");

    // Single frames: bit order, flags, inp changes after acceptance, return to IDLE.
    foreach (tbl[i]) begin
      chk_lsb = tbl[i].lsb;
      send(tbl[i].word, tbl[i].name);
      repeat (7) step(tbl[i].name);
      step({tbl[i].name, "_idle"});
    end
    chk_lsb = 1'b0;

    // Back-to-back: a write in the done cycle starts the next frame with no gap.
    send(8'b00100010, "b2b_first");
    repeat (7) step("b2b_first");
    send(8'b00011110, "b2b_second");
    repeat (7) step("b2b_second");
    step("b2b_idle");

    // Writes while ready=0 are ignored and not queued.
    send(8'b00001010, "ignored_write");
    step("ignored_write");
    write = 1'b1;
    inp   = 8'b11111111;
    repeat (6) step("ignored_write");
    write = 1'b0;
    step("ignored_write_idle");
    step("ignored_write_idle");

    // Mid-frame reset at the edge that ends bit 4: the frame is aborted.
    send(8'b01101111, "midreset");
    repeat (3) step("midreset");
    reset = 1'b0;
    exp_q.delete();
    step("midreset_abort");
    reset = 1'b1;
    repeat (10) step("midreset_no_done");

    // A write held through reset is not loaded. The first edge with reset=1 accepts it.
    reset = 1'b0;
    write = 1'b1;
    inp   = 8'b10010110;
    repeat (3) step("write_in_reset");
    reset = 1'b1;
    push_frame(8'b10010110, 1'b0);
    step("write_after_reset");
    write = 1'b0;
    repeat (7) step("write_after_reset");
    step("write_after_reset_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
